weight_cfg_tx: RTL and testbench
================================

WEIGHT_CFG_TX -- requirements
Module: weight_cfg_tx

Interface
REQ-001 The block SHALL have parameter layerNo, default 3, meaning the layer number driven on config_layer_num.
REQ-002 The block SHALL have parameter numNeuron, default 10, meaning the neurons per layer to configure.
REQ-003 The block SHALL have parameter numWeight, default 10, meaning the weights per neuron.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a layer load.
REQ-007 The block SHALL have ports s_data (input, 32 bits, stream word), s_valid (input, 1 bit) and s_ready (output, 1 bit).
REQ-008 The block SHALL have ports weightValid (output, 1 bit) and weightValue (output, 32 bits).
REQ-009 The block SHALL have ports biasValid (output, 1 bit) and biasValue (output, 32 bits).
REQ-010 The block SHALL have ports config_layer_num and config_neuron_num, outputs, 32 bits each.
REQ-011 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a load completes.
REQ-013 The block SHALL have port checksum, output, 32 bits (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, WEIGHT, BIAS and DONE.
REQ-015 IDLE -> WEIGHT SHALL occur on start=1; on entry, neuron counter=0 and weight counter=0.
REQ-016 s_ready SHALL be 1 in WEIGHT and BIAS and 0 in IDLE and DONE; a word is accepted when s_valid&s_ready.
REQ-017 In WEIGHT, each accepted word SHALL produce on the next cycle weightValid=1, weightValue=s_data, config_layer_num=layerNo and config_neuron_num=current neuron index.
REQ-018 When the weight counter reaches numWeight-1 on an accepted word, the counter SHALL clear and the FSM SHALL move to BIAS.
REQ-019 In BIAS, the single accepted word SHALL produce on the next cycle biasValid=1 and biasValue=s_data, with the same config_* values.
REQ-020 After the bias word, the neuron index SHALL increment and the FSM SHALL return to WEIGHT; if the index was numNeuron-1, the FSM SHALL go to DONE instead.
REQ-021 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-022 s_valid=0 SHALL stall the FSM: counters hold, weightValid and biasValid are 0, and config_* hold their last values.
REQ-023 start asserted while busy=1 SHALL be ignored.
REQ-024 weightValid and biasValid SHALL never be 1 in the same cycle and SHALL be 1 for exactly one cycle per accepted word.
REQ-025 Counters SHALL be $clog2 sized plus 1 bit and SHALL never wrap past numWeight-1 or numNeuron-1.
REQ-026 numWeight=1 SHALL be legal: the sequence is one weight then one bias per neuron.
REQ-027 The total words consumed per load SHALL be numNeuron*(numWeight+1).

Reset
REQ-028 While rst=0, the FSM SHALL be IDLE, all counters 0, and every output 0, including config_layer_num, config_neuron_num and checksum.
REQ-029 Reset asserted mid-load SHALL abort immediately with no done pulse; the next load restarts at neuron 0, weight 0.

Configuration
REQ-030 With macro WEIGHT_CFG_CHECKSUM_EN defined, checksum SHALL clear on start and add each accepted word modulo 2^32, updating one cycle after acceptance and stable when done=1.
REQ-031 With WEIGHT_CFG_CHECKSUM_EN undefined, checksum SHALL be constant 0 and the block SHALL contain no accumulator.

Verification
REQ-032 numNeuron=2, numWeight=3, start, then words 1..8 with s_valid held high -> weightValid pulses carry 1,2,3 on neuron 0 and 5,6,7 on neuron 1; biasValid carries 4 and 8; done fires one cycle after the last bias output.
REQ-033 The same load with s_valid toggling 1/0 every cycle -> identical output values and order, no duplicated valid pulses, and s_ready stays 1 throughout.
REQ-034 start pulsed during word 5 -> ignored; the sequence and done timing are unchanged.
REQ-035 rst=0 after word 4 -> all outputs 0 asynchronously and no done; a new start with words 1..8 -> the REQ-032 response.
REQ-036 With WEIGHT_CFG_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 in a numNeuron=1, numWeight=1 load -> checksum=0x00000001 at done; with the macro undefined -> checksum=0.

Source files
------------

// File: rtl/weight_cfg_tx.sv
// Purpose : streams numNeuron x (numWeight weights + 1 bias) config words from a valid/ready input onto weight/bias strobes.
// Latency : one cycle from word acceptance to weightValid/biasValid; done pulses one cycle after the last bias strobe.
// Backpres: s_ready is high only in WEIGHT/BIAS; s_valid=0 stalls the sequence with counters and config_* held.
//
// Ports: clk, rst (async active-low), start; s_data/s_valid/s_ready input stream;
//        weightValid/weightValue, biasValid/biasValue, config_layer_num, config_neuron_num,
//        busy, done, checksum.
// Optional feature: define WEIGHT_CFG_CHECKSUM_EN to build a running mod-2^32 sum of accepted
// words on checksum; otherwise checksum is tied to 0 and no accumulator exists.
module weight_cfg_tx #(
    parameter int layerNo   = 3,
    parameter int numNeuron = 10,
    parameter int numWeight = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        weightValid,
    output logic [31:0] weightValue,
    output logic        biasValid,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam int WCW = $clog2(numWeight) + 1;
    localparam int NCW = $clog2(numNeuron) + 1;
    localparam logic [WCW-1:0] W_LAST = WCW'(numWeight - 1);
    localparam logic [NCW-1:0] N_LAST = NCW'(numNeuron - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WEIGHT = 2'd1;
    localparam logic [1:0] S_BIAS   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]     state;
    logic [WCW-1:0] w_cnt;
    logic [NCW-1:0] n_cnt;
    logic           accept;

    assign s_ready = (state == S_WEIGHT) || (state == S_BIAS);
    assign busy    = (state != S_IDLE);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            w_cnt             <= '0;
            n_cnt             <= '0;
            weightValid       <= 1'b0;
            weightValue       <= '0;
            biasValid         <= 1'b0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            done              <= 1'b0;
        end else begin
            // Strobes are single-cycle; they only rise on an accepted word.
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WEIGHT;
                        w_cnt <= '0;
                        n_cnt <= '0;
                    end
                end
                S_WEIGHT: begin
                    if (s_valid) begin
                        weightValid       <= 1'b1;
                        weightValue       <= s_data;
                        config_layer_num  <= 32'(layerNo);
                        config_neuron_num <= 32'(n_cnt);
                        if (w_cnt == W_LAST) begin
                            w_cnt <= '0;
                            state <= S_BIAS;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                S_BIAS: begin
                    if (s_valid) begin
                        biasValid         <= 1'b1;
                        biasValue         <= s_data;
                        config_layer_num  <= 32'(layerNo);
                        config_neuron_num <= 32'(n_cnt);
                        if (n_cnt == N_LAST) begin
                            n_cnt <= '0;
                            state <= S_DONE;
                        end else begin
                            n_cnt <= n_cnt + 1'b1;
                            state <= S_WEIGHT;
                        end
                    end
                end
                S_DONE: begin
                    // Registered pulse: lands the cycle after the final bias strobe.
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WEIGHT_CFG_CHECKSUM_EN
    logic [31:0] acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if ((state == S_IDLE) && start) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc + s_data;
        end
    end

    assign checksum = acc;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign checksum      = '0;
`endif

endmodule

// File: tb/tb_weight_cfg_tx.sv
module tb_weight_cfg_tx;

    localparam int NN = 2;
    localparam int NW = 3;
    localparam int NWORDS = NN * (NW + 1);

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        weightValid;
    logic [31:0] weightValue;
    logic        biasValid;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic        start1;
    logic [31:0] s_data1;
    logic        s_valid1;
    logic        s_ready1;
    logic        weightValid1;
    logic [31:0] weightValue1;
    logic        biasValid1;
    logic [31:0] biasValue1;
    logic [31:0] config_layer_num1;
    logic [31:0] config_neuron_num1;
    logic        busy1;
    logic        done1;
    logic [31:0] checksum1;

    weight_cfg_tx #(.layerNo(3), .numNeuron(NN), .numWeight(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .busy(busy), .done(done), .checksum(checksum)
    );

    weight_cfg_tx #(.layerNo(3), .numNeuron(1), .numWeight(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .s_data(s_data1), .s_valid(s_valid1),
        .s_ready(s_ready1), .weightValid(weightValid1), .weightValue(weightValue1),
        .biasValid(biasValid1), .biasValue(biasValue1), .config_layer_num(config_layer_num1),
        .config_neuron_num(config_neuron_num1), .busy(busy1), .done(done1), .checksum(checksum1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_bias;
        logic [31:0] val;
        logic [31:0] neu;
        logic [31:0] lay;
        int          cyc;
    } ev_t;

    ev_t         obs_q[$];
    logic [31:0] words[NWORDS];
    int          cyc       = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    logic [31:0] done_ck   = '0;
    int          both_cnt  = 0;
    int          ready_low = 0;

    int          w1_cnt = 0, b1_cnt = 0, d1_cnt = 0, busy1_seen = 0;
    logic [31:0] w1_val = '0, b1_val = '0, w1_neu = '0, w1_lay = '0, d1_ck = '0;

    // Observation only; all judgements are made in the test tasks.
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (weightValid) begin
            e = '{1'b0, weightValue, config_neuron_num, config_layer_num, cyc};
            obs_q.push_back(e);
        end
        if (biasValid) begin
            e = '{1'b1, biasValue, config_neuron_num, config_layer_num, cyc};
            obs_q.push_back(e);
        end
        if (weightValid && biasValid) both_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_ck  = checksum;
        end
        if (weightValid1) begin
            w1_cnt++;
            w1_val = weightValue1;
            w1_neu = config_neuron_num1;
            w1_lay = config_layer_num1;
        end
        if (biasValid1) begin
            b1_cnt++;
            b1_val = biasValue1;
        end
        if (done1) begin
            d1_cnt++;
            d1_ck = checksum1;
        end
        if (busy1) busy1_seen++;
    end

    task automatic clear_obs();
        obs_q.delete();
        done_cnt  = 0;
        both_cnt  = 0;
        ready_low = 0;
    endtask

    // vmode 0: s_valid held high, 1: toggles every cycle, 2: random.
    task automatic drive_load(input int vmode, input bit start_mid, input int abort_after);
        int k     = 0;
        int guard = 0;
        bit tog   = 1'b1;
        bit v;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (k < NWORDS && guard < 200) begin
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data  = words[k];
            start   = (start_mid && k == 4);
            if (s_ready !== 1'b1) ready_low++;
            if (v && s_ready) k++;
            @(negedge clk);
            guard++;
            if (abort_after > 0 && k == abort_after) break;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        vectors++;
        if (guard >= 200) begin
            miscompares++;
            $display("FAIL load_timeout: consumed %0d words, required %0d", k, NWORDS);
        end
    endtask

    // Expected response derived directly from word index: neuron = k/(NW+1), last slot = bias.
    task automatic check_load(input string tag);
        int          last_bias_cyc = -1;
        logic [31:0] sum = '0;
        ev_t         o;
        bit          exp_bias;
        logic [31:0] exp_neu;
        repeat (6) @(negedge clk);
        vectors++;
        if (obs_q.size() !== NWORDS) begin
            miscompares++;
            $display("FAIL %s_count: got %0d strobes, required %0d", tag, obs_q.size(), NWORDS);
        end
        for (int k = 0; k < NWORDS && k < obs_q.size(); k++) begin
            o        = obs_q[k];
            exp_bias = ((k % (NW + 1)) == NW);
            exp_neu  = 32'(k / (NW + 1));
            sum      = sum + words[k];
            if (o.is_bias) last_bias_cyc = o.cyc;
            vectors++;
            if (o.is_bias !== exp_bias || o.val !== words[k] || o.neu !== exp_neu || o.lay !== 32'd3) begin
                miscompares++;
                $display("FAIL %s_ev%0d: got bias=%0d val=%h neu=%0d lay=%0d, required bias=%0d val=%h neu=%0d lay=3",
                         tag, k, o.is_bias, o.val, o.neu, o.lay, exp_bias, words[k], exp_neu);
            end
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt);
        end
        vectors++;
        if (done_cyc !== last_bias_cyc + 1) begin
            miscompares++;
            $display("FAIL %s_done_timing: got cycle %0d, required %0d", tag, done_cyc, last_bias_cyc + 1);
        end
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL %s_overlap: got %0d cycles with both strobes, required 0", tag, both_cnt);
        end
        vectors++;
        if (ready_low !== 0) begin
            miscompares++;
            $display("FAIL %s_ready: got %0d cycles s_ready low mid-load, required 0", tag, ready_low);
        end
`ifndef WEIGHT_CFG_CHECKSUM_EN
        sum = '0;
`endif
        vectors++;
        if (done_ck !== sum) begin
            miscompares++;
            $display("FAIL %s_checksum: got %h, required %h", tag, done_ck, sum);
        end
    endtask

    task automatic set_seq_words();
        for (int k = 0; k < NWORDS; k++) words[k] = 32'(k + 1);
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({weightValid, biasValid, done, busy, s_ready} !== 5'b0) begin
            miscompares++;
            $display("FAIL %s_ctrl: got wv/bv/done/busy/rdy=%b, required 00000", tag,
                     {weightValid, biasValid, done, busy, s_ready});
        end
        vectors++;
        if (weightValue !== '0 || biasValue !== '0) begin
            miscompares++;
            $display("FAIL %s_values: got w=%h b=%h, required 0", tag, weightValue, biasValue);
        end
        vectors++;
        if (config_layer_num !== '0 || config_neuron_num !== '0) begin
            miscompares++;
            $display("FAIL %s_config: got layer=%h neuron=%h, required 0", tag,
                     config_layer_num, config_neuron_num);
        end
        vectors++;
        if (checksum !== '0) begin
            miscompares++;
            $display("FAIL %s_checksum: got %h, required 0", tag, checksum);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stream();
        set_seq_words();
        clear_obs();
        drive_load(0, 1'b0, 0);
        check_load("stream");
    endtask

    task automatic test_toggle_valid();
        set_seq_words();
        clear_obs();
        drive_load(1, 1'b0, 0);
        check_load("toggle");
    endtask

    task automatic test_start_while_busy();
        set_seq_words();
        clear_obs();
        drive_load(0, 1'b1, 0);
        check_load("busy_start");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < NWORDS; k++) words[k] = $urandom;
            clear_obs();
            drive_load(2, 1'(it & 1), 0);
            check_load("random");
        end
    endtask

    task automatic test_abort();
        set_seq_words();
        clear_obs();
        drive_load(0, 1'b0, 4);
        #2 rst = 1'b0;
        #1 check_all_zero("abort");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d done pulses, required 0", done_cnt);
        end
        clear_obs();
        drive_load(0, 1'b0, 0);
        check_load("after_abort");
    endtask

    task automatic test_single_weight();
        logic [31:0] w1[2];
        logic [31:0] exp_ck;
        int          k     = 0;
        int          guard = 0;
        w1[0] = 32'hFFFF_FFFF;
        w1[1] = 32'h0000_0002;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        while (k < 2 && guard < 50) begin
            s_valid1 = 1'b1;
            s_data1  = w1[k];
            if (s_ready1) k++;
            @(negedge clk);
            guard++;
        end
        s_valid1 = 1'b0;
        repeat (5) @(negedge clk);
`ifdef WEIGHT_CFG_CHECKSUM_EN
        exp_ck = 32'h0000_0001;
`else
        exp_ck = 32'h0;
`endif
        vectors++;
        if (w1_cnt !== 1 || w1_val !== 32'hFFFF_FFFF || w1_neu !== '0 || w1_lay !== 32'd3) begin
            miscompares++;
            $display("FAIL nw1_weight: got cnt=%0d val=%h neu=%0d lay=%0d, required 1 ffffffff 0 3",
                     w1_cnt, w1_val, w1_neu, w1_lay);
        end
        vectors++;
        if (b1_cnt !== 1 || b1_val !== 32'h2) begin
            miscompares++;
            $display("FAIL nw1_bias: got cnt=%0d val=%h, required 1 00000002", b1_cnt, b1_val);
        end
        vectors++;
        if (d1_cnt !== 1 || busy1_seen < 3) begin
            miscompares++;
            $display("FAIL nw1_done: got done=%0d busy_cycles=%0d, required 1 and >=3", d1_cnt, busy1_seen);
        end
        vectors++;
        if (d1_ck !== exp_ck) begin
            miscompares++;
            $display("FAIL nw1_checksum: got %h, required %h", d1_ck, exp_ck);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        start1   = 1'b0;
        s_valid1 = 1'b0;
        s_data1  = '0;
        test_reset();
        test_stream();
        test_toggle_valid();
        test_start_while_busy();
        test_abort();
        test_random();
        test_single_weight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
